// File: rtl/uart_tx_queue.sv
// Transmit FIFO plus issue sequencer feeding the UART transmitter's send/data/ready handshake.
// Lost words (FIFO overflow, transmitter that never goes busy) are reported through sticky flags.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 9,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   flush,
  input  logic                   tx_ready,
  output logic                   tx_send,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_lost
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             ready_q;
  logic [TW-1:0]    busy_timer;
  logic             wr_accept;
  logic             pop;

  // full/empty decode the registered count, so they never depend on this cycle's inputs.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign wr_accept = wr_en && !full && !flush;
  assign pop       = (state == IDLE) && !empty && tx_ready && ready_q && !flush;

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_accept && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !wr_accept) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Requiring ready on two consecutive cycles skips the one-cycle ready blip of the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      ready_q    <= 1'b0;
      busy_timer <= '0;
      tx_lost    <= 1'b0;
    end else begin
      ready_q <= tx_ready;
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_send <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          busy_timer <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= WAIT_READY;
          end else if (busy_timer + 1'b1 == TIMEOUT_LAST) begin
            tx_lost <= 1'b1;
            state   <= IDLE;
          end else begin
            busy_timer <= busy_timer + 1'b1;
          end
        end
        WAIT_READY: begin
          if (tx_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
